// File: rtl/tx_scrambler_framer.sv
// Bit-serial 802.11a transmit framer: emits the SIGNAL header bits, then the scrambled
// DATA field (SERVICE, PSDU, tail, pad) through a single-stage valid/ready output register.
module tx_scrambler_framer #(
    parameter logic [6:0] DEFAULT_SEED = 7'h7F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  cfg_rate,
    input  logic [11:0] cfg_length,
    input  logic [6:0]  cfg_seed,
    output logic        cfg_err,
    output logic        busy,
    output logic        done,
    input  logic        in_bit,
    input  logic        in_val,
    output logic        in_rdy,
    output logic        data_out,
    output logic        ostream_val,
    input  logic        ostream_rdy
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SERVICE,
        PSDU,
        TAIL,
        PAD,
        DONE
    } state_t;

    // Data bits per OFDM symbol; zero marks an illegal RATE code.
    function automatic logic [7:0] rate_ndbps(input logic [3:0] rate);
        case (rate)
            4'b1101: rate_ndbps = 8'd24;
            4'b1111: rate_ndbps = 8'd36;
            4'b0101: rate_ndbps = 8'd48;
            4'b0111: rate_ndbps = 8'd72;
            4'b1001: rate_ndbps = 8'd96;
            4'b1011: rate_ndbps = 8'd144;
            4'b0001: rate_ndbps = 8'd192;
            4'b0011: rate_ndbps = 8'd216;
            default: rate_ndbps = 8'd0;
        endcase
    endfunction

    state_t      state, state_next;
    logic [3:0]  rate_q;
    logic [11:0] len_q;
    logic [7:0]  ndbps_q;
    logic [14:0] cnt;
    logic [7:0]  sym_cnt;
    logic [6:0]  scr;

    logic        load_en;
    logic        fire;
    logic        obit;
    logic        scr_adv;
    logic        fb;
    logic [7:0]  sym_inc;
    logic [15:0] hdr_word;
    logic        psdu_last;
    logic [7:0]  start_ndbps;

    assign load_en     = !ostream_val || ostream_rdy;
    assign fb          = scr[6] ^ scr[3];
    assign sym_inc     = (sym_cnt == ndbps_q - 8'd1) ? 8'd0 : sym_cnt + 8'd1;
    assign hdr_word    = {len_q, rate_q};
    assign psdu_last   = (cnt == {len_q, 3'b000} - 15'd1);
    assign start_ndbps = rate_ndbps(cfg_rate);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: every register update uses <= so all flops see the pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_next = state;
        fire       = 1'b0;
        obit       = 1'b0;
        scr_adv    = 1'b0;
        in_rdy     = 1'b0;
        cfg_err    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_ndbps != 8'd0) state_next = HDR;
                    else                     cfg_err    = 1'b1;
                end
            end
            HDR: begin
                if (load_en) begin
                    fire = 1'b1;
                    obit = hdr_word[cnt[3:0]];
                    if (cnt == 15'd15) state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (load_en) begin
                    fire    = 1'b1;
                    scr_adv = 1'b1;
                    obit    = fb;
                    if (cnt == 15'd15) state_next = (len_q == 12'd0) ? TAIL : PSDU;
                end
            end
            PSDU: begin
                in_rdy = load_en;
                if (in_val && load_en) begin
                    fire    = 1'b1;
                    scr_adv = 1'b1;
                    obit    = in_bit ^ fb;
                    if (psdu_last) state_next = TAIL;
                end
            end
            TAIL: begin
                if (load_en) begin
                    fire    = 1'b1;
                    scr_adv = 1'b1;
                    if (cnt == 15'd5) state_next = (sym_inc != 8'd0) ? PAD : DONE;
                end
            end
            PAD: begin
                if (load_en) begin
                    fire    = 1'b1;
                    scr_adv = 1'b1;
                    obit    = fb;
                    if (sym_inc == 8'd0) state_next = DONE;
                end
            end
            DONE: begin
                // Wait for the last loaded bit to drain downstream before reporting completion.
                if (!ostream_val) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && !done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_q      <= '0;
            len_q       <= '0;
            ndbps_q     <= '0;
            cnt         <= '0;
            sym_cnt     <= '0;
            scr         <= '0;
            data_out    <= 1'b0;
            ostream_val <= 1'b0;
        end else begin
            if (state == IDLE && state_next == HDR) begin
                rate_q  <= cfg_rate;
                len_q   <= cfg_length;
                ndbps_q <= start_ndbps;
                scr     <= (cfg_seed == 7'd0) ? DEFAULT_SEED : cfg_seed;
            end else if (fire && scr_adv) begin
                scr <= {scr[5:0], fb};
            end

            if (state != state_next) cnt <= '0;
            else if (fire)           cnt <= cnt + 15'd1;

            if (state == HDR && state_next == SERVICE) sym_cnt <= '0;
            else if (fire && scr_adv)                  sym_cnt <= sym_inc;

            if (fire) begin
                ostream_val <= 1'b1;
                data_out    <= obit;
            end else if (load_en) begin
                ostream_val <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_scrambler_framer.sv
// Scoreboard bench for tx_scrambler_framer: a frame-level reference model queues the
// expected serial stream, and an independent monitor compares every accepted output bit.
module tb_tx_scrambler_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  cfg_rate;
    logic [11:0] cfg_length;
    logic [6:0]  cfg_seed;
    logic        cfg_err;
    logic        busy;
    logic        done;
    logic        in_bit;
    logic        in_val;
    logic        in_rdy;
    logic        data_out;
    logic        ostream_val;
    logic        ostream_rdy;

    tx_scrambler_framer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_rate    (cfg_rate),
        .cfg_length  (cfg_length),
        .cfg_seed    (cfg_seed),
        .cfg_err     (cfg_err),
        .busy        (busy),
        .done        (done),
        .in_bit      (in_bit),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .data_out    (data_out),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit exp_q[$];
    bit got_q[$];
    bit ref_q[$];
    bit psdu[$];

    int xfer_cnt;
    int done_cnt;
    bit in_rdy_seen;
    bit prev_stall;
    bit prev_bit;

    logic [3:0] legal_rate [8] = '{4'hD, 4'hF, 4'h5, 4'h7, 4'h9, 4'hB, 4'h1, 4'h3};
    int         legal_nd   [8] = '{24, 36, 48, 72, 96, 144, 192, 216};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int ndbps_of(input logic [3:0] rate);
        int n = 0;
        for (int i = 0; i < 8; i++) if (legal_rate[i] == rate) n = legal_nd[i];
        return n;
    endfunction

    // Reference frame: header LSB-first, then the DATA field as a flat bit list
    // scrambled by the x^7+x^4+1 sequence, with the six tail positions forced to zero.
    task automatic push_expected(input logic [3:0] rate, input logic [11:0] len,
                                 input logic [6:0] seed_in, output int total);
        int         n     = ndbps_of(rate);
        int         ndata = 22 + 8 * int'(len);
        int         nsym  = (ndata + n - 1) / n;
        int         psdu_end = 16 + 8 * int'(len);
        logic [6:0] s     = (seed_in == 7'd0) ? 7'h7F : seed_in;
        bit         raw, fbit;
        for (int i = 0; i < 4; i++)  exp_q.push_back(rate[i]);
        for (int i = 0; i < 12; i++) exp_q.push_back(len[i]);
        for (int k = 0; k < nsym * n; k++) begin
            raw  = (k >= 16 && k < psdu_end) ? psdu[k - 16] : 1'b0;
            fbit = s[6] ^ s[3];
            s    = {s[5:0], fbit};
            if (k >= psdu_end && k < psdu_end + 6) exp_q.push_back(1'b0);
            else                                   exp_q.push_back(raw ^ fbit);
        end
        total = 16 + nsym * n;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", {ostream_val, data_out}, {1'b1, prev_bit});
            if (in_rdy) in_rdy_seen = 1'b1;
            if (done) done_cnt++;
            if (ostream_val && ostream_rdy) begin
                got_q.push_back(data_out);
                xfer_cnt++;
                if (exp_q.size() == 0) check("extra_bit", exp_q.size(), 1);
                else                   check("data_bit", data_out, exp_q.pop_front());
            end
            prev_stall = ostream_val && !ostream_rdy;
            prev_bit   = data_out;
        end
    end

    task automatic run_frame(input logic [3:0] rate, input logic [11:0] len,
                             input logic [6:0] seed, input bit stall,
                             input bit keep_psdu, input int abort_at);
        int total, cyc, idx, budget;
        bit fin;
        if (!keep_psdu) begin
            psdu.delete();
            for (int i = 0; i < 8 * int'(len); i++) psdu.push_back(1'($urandom % 2));
        end
        exp_q.delete();
        push_expected(rate, len, seed, total);
        got_q.delete();
        xfer_cnt    = 0;
        done_cnt    = 0;
        in_rdy_seen = 1'b0;
        budget      = 8 * total + 200;

        @(posedge clk); #1;
        start = 1'b1; cfg_rate = rate; cfg_length = len; cfg_seed = seed;
        ostream_rdy = 1'b1; in_val = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_rate = 4'($urandom); cfg_length = 12'($urandom); cfg_seed = 7'($urandom);
        check("busy_after_start", busy, 1);

        cyc = 0; idx = 0; fin = 1'b0;
        while (!fin && cyc < budget) begin
            ostream_rdy = stall ? 1'($urandom % 2) : 1'b1;
            if (idx < 8 * int'(len)) begin
                in_bit = psdu[idx];
                in_val = stall ? ($urandom % 4 != 0) : 1'b1;
            end else begin
                in_val = 1'b0;
            end
            start = (cyc == 10);
            @(negedge clk);
            if (in_val && in_rdy) idx++;
            if (done) fin = 1'b1;
            if (abort_at > 0 && cyc == abort_at) begin
                @(posedge clk); #1;
                reset = 1'b1;
                #1;
                check("reset_mid_outputs",
                      {ostream_val, data_out, in_rdy, busy, done, cfg_err}, 6'b0);
                @(posedge clk); #1;
                reset = 1'b0; start = 1'b0; in_val = 1'b0;
                exp_q.delete();
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; in_val = 1'b0; ostream_rdy = 1'b1;
        check("frame_done_seen", fin, 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulse_count", done_cnt, 1);
        check("busy_after_done", busy, 0);
        check("total_bits", xfer_cnt, total);
        check("queue_drained", exp_q.size(), 0);
        check("psdu_bits_taken", idx, 8 * int'(len));
    endtask

    initial begin
        logic [15:0] hdr;
        logic [7:0]  svc;
        int          tpos;
        reset = 1'b1; start = 1'b0; cfg_rate = '0; cfg_length = '0; cfg_seed = '0;
        in_bit = 1'b0; in_val = 1'b0; ostream_rdy = 1'b1;
        xfer_cnt = 0; done_cnt = 0; in_rdy_seen = 1'b0; prev_stall = 1'b0; prev_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {ostream_val, data_out, in_rdy, busy, done, cfg_err}, 6'b0);
        reset = 1'b0;

        // Smallest nonempty frame at 6 Mb/s: explicit header, SERVICE and tail bits.
        run_frame(4'b1101, 12'd1, 7'h7F, 1'b0, 1'b0, 0);
        check("len1_total", got_q.size(), 64);
        hdr = {12'd1, 4'b1101};
        for (int i = 0; i < 16; i++) check("hdr_bit", got_q[i], hdr[i]);
        svc = 8'h70;
        for (int i = 0; i < 8; i++) check("service_bit", got_q[16 + i], svc[i]);
        tpos = 16 + 16 + 8;
        for (int i = 0; i < 6; i++) check("tail_bit", got_q[tpos + i], 0);
        ref_q = got_q;

        // Seed 0 must fall back to the default seed.
        run_frame(4'b1101, 12'd1, 7'h00, 1'b0, 1'b1, 0);
        check("seed0_len", got_q.size(), ref_q.size());
        for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
            check("seed0_bit", got_q[i], ref_q[i]);

        run_frame(4'b0011, 12'd100, 7'h55, 1'b0, 1'b0, 0);
        check("len100_total", got_q.size(), 880);

        run_frame(4'b1101, 12'd0, 7'h7F, 1'b0, 1'b0, 0);
        check("len0_total", got_q.size(), 40);
        check("len0_in_rdy_never", in_rdy_seen, 0);

        run_frame(4'b1001, 12'd40, 7'h2A, 1'b1, 1'b0, 0);

        // Illegal RATE is rejected with a single-cycle error pulse.
        @(posedge clk); #1;
        start = 1'b1; cfg_rate = 4'b0000; cfg_length = 12'd5;
        @(negedge clk);
        check("illegal_cfg_err", cfg_err, 1);
        check("illegal_busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("illegal_err_clear", cfg_err, 0);
        check("illegal_busy_after", busy, 0);

        // Reset in the middle of the PSDU, then a clean frame.
        run_frame(4'b0101, 12'd50, 7'h13, 1'b0, 1'b0, 60);
        run_frame(4'b0101, 12'd3, 7'h13, 1'b0, 1'b0, 0);

        for (int f = 0; f < 4; f++) begin
            int r = $urandom_range(0, 7);
            run_frame(legal_rate[r], 12'($urandom_range(0, 120)), 7'($urandom),
                      1'($urandom % 2), 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_scrambler_framer.md
Name: tx_scrambler_framer

Overview:
- Stage directly upstream of the 802.11a transmitter datapath/control pair; drives its bit-serial data_in / istream_val / istream_rdy interface.
- Per frame, emits the unscrambled SIGNAL header bits (RATE, LENGTH) that downstream captures into its rate/length FIFOs.
- Then emits the DATA field: SERVICE, scrambled PSDU, zeroed tail and scrambled pad bits, filling the last OFDM symbol to an integer multiple of N_DBPS.

Parameters:
DEFAULT_SEED, 7'h7F, scrambler seed substituted when cfg_seed == 0.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  frame start strobe; sampled only in IDLE
cfg_rate  input  4  RATE code, captured on an accepted start
cfg_length  input  12  PSDU length in bytes (0..4095), captured on an accepted start
cfg_seed  input  7  scrambler initial state, captured on an accepted start
cfg_err  output  1  one-cycle pulse: start with an illegal rate was rejected
busy  output  1  high from an accepted start until the done pulse
done  output  1  one-cycle pulse after the last frame bit is accepted downstream
in_bit  input  1  PSDU bit, LSB of each byte first
in_val  input  1  PSDU bit valid
in_rdy  output  1  PSDU bit accepted when in_val && in_rdy
data_out  output  1  serial bit to downstream data_in
ostream_val  output  1  data_out valid
ostream_rdy  input  1  downstream ready (its istream_rdy)

Behaviour:
- Reset (async, any state, mid-frame included): state=IDLE, all counters 0, data_out=0, ostream_val=0, in_rdy=0, busy=0, done=0, cfg_err=0. A partial frame is discarded and nothing resumes.
- Legal rates and N_DBPS: 1101:24, 1111:36, 0101:48, 0111:72, 1001:96, 1011:144, 0001:192, 0011:216.
- Illegal rate on start: pulse cfg_err, stay in IDLE.
- Output register: single stage. A new bit loads when !ostream_val || ostream_rdy. ostream_val and data_out stay stable while ostream_val && !ostream_rdy.
- Transfer rule: a bit advances only on ostream_val && ostream_rdy.
- States:
  - IDLE: legal start -> HDR; capture cfg_rate, cfg_length and seed (cfg_seed, or DEFAULT_SEED if cfg_seed == 0); busy=1.
  - HDR: 16 bits, unscrambled: rate[0..3] then length[0..11], LSB first -> SERVICE.
  - SERVICE: 16 zero bits, scrambled -> PSDU, or -> TAIL if length == 0.
  - PSDU: 8*length bits from in_bit, scrambled -> TAIL.
    - in_rdy = (state==PSDU) && (!ostream_val || ostream_rdy).
    - Zero-bubble throughput when both sides are ready.
    - Input latency is 1 cycle (accept to ostream_val).
  - TAIL: 6 bits, forced 0 (the scrambler still advances) -> PAD if sym_cnt != 0 after the last tail bit, else DONE.
  - PAD: scrambled zero bits until sym_cnt wraps to 0 -> DONE.
  - DONE: the final output bit has been accepted; pulse done for 1 cycle, busy=0 -> IDLE.
- Scrambler:
  - Polynomial x^7+x^4+1: fb = s[6]^s[3]; s <= {s[5:0],fb}; out = in ^ fb.
  - Advances once per transferred DATA-field bit (SERVICE/PSDU/TAIL/PAD), never during HDR.
- sym_cnt:
  - Cleared entering SERVICE; increments per transferred DATA-field bit; wraps N_DBPS-1 -> 0.
  - Width 8 bits.
  - Pad count = (N_DBPS - (22+8L) mod N_DBPS) mod N_DBPS.
- PSDU bit counter is 15 bits (max 32760).
- start is ignored while busy; cfg_* changes during a frame have no effect.
- Total output bits = 16 + N_SYM*N_DBPS, where N_SYM = ceil((22+8L)/N_DBPS).

Test Plan:
- rate=1101, length=1, seed=7F, both sides always ready -> 64 output bits: header 1011 + length LSB-first 100000000000, then 48 data bits (18 pad); done pulses once; busy low afterwards.
- seed=7F, any legal rate -> first 8 SERVICE output bits = 0,0,0,0,1,1,1,0; tail bits are all 0; cfg_seed=0 gives output identical to cfg_seed=7F.
- rate=0011, length=100 -> 822 DATA bits + 42 pad = 864 DATA bits (4 symbols), 880 total; sym_cnt = 0 at done.
- rate=1101, length=0 -> SERVICE+TAIL = 22 bits, pad 2, 40 bits total; in_rdy is never asserted.
- Random ostream_rdy deassertion (about 50%) during PSDU -> data_out stable while stalled; no bits lost or duplicated; output matches the unstalled golden stream.
- Illegal rate 0000 on start -> cfg_err pulse, busy stays 0; async reset mid-PSDU -> outputs 0 immediately, and the next legal start produces a clean frame.
